mac_seq_ctrl: RTL and testbench

Sequencer for one dense-layer neuron. On `start` it walks the activation and weight buffers from address 0 to `num_inputs`-1 and accumulates the signed products onto a bias. It then presents the result on a valid/ready output port. It sits between the layer buffers and the activation/output stage, and it owns both the MAC enable and the accumulator register.

---
 rtl/mac_seq_ctrl.sv | 130 +++++++++++++
 tb/tb_mac_seq_ctrl.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mac_seq_ctrl
// Brief    : Dense-layer neuron sequencer. It walks the activation and weight
//            buffers and accumulates signed products onto a bias. The result
//            leaves on a valid/ready port. Optional macro RELU_EN clamps
//            negative results to zero.
// Revision : 1.0 - initial release
// ============================================================================
module mac_seq_ctrl #(
    parameter int INPUT_BITWIDTH = 16,
    parameter int ACC_BITWIDTH   = 2*INPUT_BITWIDTH+8,
    parameter int ADDR_WIDTH     = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [ADDR_WIDTH:0]       num_inputs,
    input  logic [INPUT_BITWIDTH-1:0] bias,
    output logic                      busy,
    output logic                      rd_en,
    output logic [ADDR_WIDTH-1:0]     rd_addr,
    input  logic [INPUT_BITWIDTH-1:0] a_in,
    input  logic [INPUT_BITWIDTH-1:0] w_in,
    output logic [ACC_BITWIDTH-1:0]   result,
    output logic                      result_valid,
    input  logic                      result_ready
);

    localparam int                  c_PROD_W   = 2*INPUT_BITWIDTH;
    localparam logic [ADDR_WIDTH:0] c_N_ONE    = {{ADDR_WIDTH{1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH-1:0] c_A_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2,
        ST_OUT   = 2'd3
    } state_t;

    state_t                    r_state;
    state_t                    w_state_next;
    logic [ADDR_WIDTH:0]       r_n;
    logic [ADDR_WIDTH-1:0]     r_count;
    logic                      r_mac_en;
    logic [ACC_BITWIDTH-1:0]   r_acc;
    logic [ACC_BITWIDTH-1:0]   r_result;

    logic signed [c_PROD_W-1:0] w_prod;
    logic [ACC_BITWIDTH-1:0]    w_prod_ext;
    logic [ACC_BITWIDTH-1:0]    w_bias_ext;
    logic [ACC_BITWIDTH-1:0]    w_acc_sum;
    logic                       w_last;
    logic                       w_start_ok;

    assign w_prod     = $signed(a_in) * $signed(w_in);
    assign w_prod_ext = {{(ACC_BITWIDTH-c_PROD_W){w_prod[c_PROD_W-1]}}, w_prod};
    assign w_bias_ext = {{(ACC_BITWIDTH-INPUT_BITWIDTH){bias[INPUT_BITWIDTH-1]}}, bias};
    // Includes the product landing this edge, so the DRAIN edge captures the full sum.
    assign w_acc_sum  = r_mac_en ? (r_acc + w_prod_ext) : r_acc;
    assign w_last     = ({1'b0, r_count} == (r_n - c_N_ONE));
    assign w_start_ok = (r_state == ST_IDLE) && start;

    function automatic logic [ACC_BITWIDTH-1:0] f_finalize(input logic [ACC_BITWIDTH-1:0] v);
`ifdef RELU_EN
        return v[ACC_BITWIDTH-1] ? '0 : v;
`else
        return v;
`endif
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:  if (start) w_state_next = (num_inputs == '0) ? ST_OUT : ST_FETCH;
            ST_FETCH: if (w_last) w_state_next = ST_DRAIN;
            ST_DRAIN: w_state_next = ST_OUT;
            ST_OUT:   if (result_ready) w_state_next = ST_IDLE;
            default:  w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_n      <= '0;
            r_count  <= '0;
            r_mac_en <= 1'b0;
            r_acc    <= '0;
            r_result <= '0;
        end else begin
            r_mac_en <= (r_state == ST_FETCH);

            if (w_start_ok) begin
                r_n     <= num_inputs;
                r_count <= '0;
            end else if ((r_state == ST_FETCH) && !w_last) begin
                r_count <= r_count + c_A_ONE;
            end

            if (w_start_ok) begin
                r_acc <= w_bias_ext;
            end else if (r_mac_en) begin
                r_acc <= w_acc_sum;
            end

            // The result register only loads on entry to OUT.
            if (w_start_ok && (num_inputs == '0)) begin
                r_result <= f_finalize(w_bias_ext);
            end else if (r_state == ST_DRAIN) begin
                r_result <= f_finalize(w_acc_sum);
            end
        end
    end

    assign busy         = (r_state != ST_IDLE);
    assign rd_en        = (r_state == ST_FETCH);
    assign rd_addr      = r_count;
    assign result       = r_result;
    assign result_valid = (r_state == ST_OUT);

endmodule
`default_nettype wire

// File: tb/tb_mac_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mac_seq_ctrl
// Brief    : Self-checking bench for mac_seq_ctrl. It uses a transaction-level
//            model and per-cycle output comparison.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mac_seq_ctrl;

    localparam int IW   = 16;
    localparam int AW   = 8;
    localparam int ACCW = 2*IW+8;

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic [AW:0]     num_inputs;
    logic [IW-1:0]   bias;
    logic            busy;
    logic            rd_en;
    logic [AW-1:0]   rd_addr;
    logic [IW-1:0]   a_in = '0;
    logic [IW-1:0]   w_in = '0;
    logic [ACCW-1:0] result;
    logic            result_valid;
    logic            result_ready;

    logic signed [IW-1:0] a_mem [256];
    logic signed [IW-1:0] w_mem [256];

    int total = 0;
    int bad   = 0;

    mac_seq_ctrl #(.INPUT_BITWIDTH(IW), .ACC_BITWIDTH(ACCW), .ADDR_WIDTH(AW)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .num_inputs   (num_inputs),
        .bias         (bias),
        .busy         (busy),
        .rd_en        (rd_en),
        .rd_addr      (rd_addr),
        .a_in         (a_in),
        .w_in         (w_in),
        .result       (result),
        .result_valid (result_valid),
        .result_ready (result_ready)
    );

    always #5 clk = ~clk;

    // Synchronous buffers: data appears one cycle after the read strobe.
    always @(posedge clk) begin
        if (rd_en) begin
            a_in <= a_mem[rd_addr];
            w_in <= w_mem[rd_addr];
        end
    end

    task automatic check(input string name, input logic [ACCW-1:0] act, input logic [ACCW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Transaction model: bias plus dot product modulo 2^ACCW, then optional clamp.
    function automatic logic [ACCW-1:0] model_result(input int n, input logic [IW-1:0] b);
        longint          s;
        logic [ACCW-1:0] r;
        s = longint'($signed(b));
        for (int i = 0; i < n; i++) s += longint'(a_mem[i]) * longint'(w_mem[i]);
        r = s[ACCW-1:0];
`ifdef RELU_EN
        if (r[ACCW-1]) r = '0;
`endif
        return r;
    endfunction

    function automatic int valid_from(input int n);
        return (n == 0) ? 0 : n + 1;
    endfunction

    int              cyc = 0;
    int              m_t0 = 0;
    int              m_n = 0;
    bit              m_active = 1'b0;
    logic [ACCW-1:0] m_exp = '0;
    logic [ACCW-1:0] m_hold = '0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_active = 1'b0;
            m_hold   = '0;
        end else begin
            if (!m_active) begin
                if (start) begin
                    m_active = 1'b1;
                    m_t0     = cyc + 1;
                    m_n      = int'(num_inputs);
                    m_exp    = model_result(m_n, bias);
                end
            end else if ((cyc - m_t0) >= valid_from(m_n) && result_ready) begin
                m_active = 1'b0;
                m_hold   = m_exp;
            end
            cyc++;
        end
    end

    int cmp_d;
    bit cmp_rd;
    bit cmp_v;

    always @(negedge clk) begin
        if (rst) begin
            check("rst_busy", busy, 0);
            check("rst_rd_en", rd_en, 0);
            check("rst_rd_addr", rd_addr, 0);
            check("rst_valid", result_valid, 0);
            check("rst_result", result, 0);
        end else begin
            cmp_d  = cyc - m_t0;
            cmp_rd = m_active && (cmp_d < m_n);
            cmp_v  = m_active && (cmp_d >= valid_from(m_n));
            check("busy", busy, m_active);
            check("rd_en", rd_en, cmp_rd);
            if (cmp_rd) check("rd_addr", rd_addr, cmp_d[AW-1:0]);
            check("result_valid", result_valid, cmp_v);
            check("result", result, cmp_v ? m_exp : m_hold);
        end
    end

    task automatic run_op(input int n, input int b, input int hold,
                          output logic [ACCW-1:0] res, output int lat);
        int c;
        @(posedge clk); #2;
        num_inputs   = n[AW:0];
        bias         = b[IW-1:0];
        start        = 1'b1;
        result_ready = (hold == 0);
        @(posedge clk); #2;
        start = 1'b0;
        c   = 0;
        lat = -1;
        while (c < 2000) begin
            @(negedge clk);
            c++;
            if (result_valid) begin
                lat = c;
                break;
            end
        end
        if (lat < 0) begin
            total++;
            bad++;
            $display("FAIL timeout: result_valid never rose for n=%0d", n);
        end
        res = result;
        if (hold > 0) begin
            for (int k = 0; k < hold; k++) begin
                @(posedge clk); #2;
                start      = 1'b1;
                num_inputs = 5;
            end
            @(negedge clk);
            check("hold_valid", result_valid, 1);
            check("hold_result", result, res);
            @(posedge clk); #2;
            result_ready = 1'b1;
            @(posedge clk); #2;
            start = 1'b0;
            @(negedge clk);
            check("start_at_handshake_ignored", busy, 0);
        end else begin
            @(negedge clk);
            check("valid_one_cycle", result_valid, 0);
        end
    endtask

    logic [ACCW-1:0] res;
    logic [ACCW-1:0] exp_v;
    int              lat;

    initial begin
        rst          = 1'b1;
        start        = 1'b0;
        result_ready = 1'b1;
        num_inputs   = '0;
        bias         = '0;
        for (int i = 0; i < 256; i++) begin
            a_mem[i] = '0;
            w_mem[i] = '0;
        end
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        repeat (5) @(negedge clk);
        check("idle_busy", busy, 0);
        check("idle_result", result, 0);

        for (int i = 0; i < 4; i++) begin
            a_mem[i] = 16'(i + 1);
            w_mem[i] = 16'(i + 5);
        end
        run_op(4, 10, 0, res, lat);
        check("basic_result", res, 40'd80);
        check("basic_latency", lat, 6);

        a_mem[0] = -16'sd3; a_mem[1] = 16'sd2;
        w_mem[0] = 16'sd4;  w_mem[1] = 16'sd1;
`ifdef RELU_EN
        exp_v = '0;
`else
        exp_v = 40'hFF_FFFF_FFF6;
`endif
        run_op(2, 0, 0, res, lat);
        check("signed_result", res, exp_v);
        check("signed_latency", lat, 4);

`ifdef RELU_EN
        exp_v = '0;
`else
        exp_v = 40'hFF_FFFF_FFF9;
`endif
        run_op(0, -7, 5, res, lat);
        check("n0_result", res, exp_v);
        check("n0_latency", lat, 1);

        for (int i = 0; i < 256; i++) begin
            a_mem[i] = 16'sh7FFF;
            w_mem[i] = 16'sh7FFF;
        end
        run_op(256, 0, 0, res, lat);
        check("full_result", res, 40'h3F_FF00_0100);
        check("full_latency", lat, 258);

        @(posedge clk); #2;
        num_inputs = 8;
        bias       = 16'd3;
        start      = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        repeat (3) @(negedge clk);
        #1 rst = 1'b1;
        #1;
        check("abort_busy", busy, 0);
        check("abort_rd_en", rd_en, 0);
        check("abort_rd_addr", rd_addr, 0);
        check("abort_valid", result_valid, 0);
        check("abort_result", result, 0);
        @(posedge clk); #2;
        rst = 1'b0;

        a_mem[0] = 16'sd2;
        w_mem[0] = 16'sd3;
        run_op(1, 1, 0, res, lat);
        check("after_abort_result", res, 40'd7);
        check("after_abort_latency", lat, 3);

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
`default_nettype wire
